// File: rtl/dff_share_arbiter.sv
// dff_share_arbiter: round-robin scheduler that lets N_REQ requesters take
// turns writing one shared WIDTH-bit register Q. The grant holder's data is
// captured on every edge it still requests. A hold limit forces rotation so
// that no requester can starve the others.
// Optional feature: define DFF_ARB_LOCK_EN to add a 'lock' input. While lock
// is high, an owner that is still requesting keeps the grant past the limit.
module dff_share_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   D,
`ifdef DFF_ARB_LOCK_EN
    input  logic                     lock,
`endif
    output logic [N_REQ-1:0]         gnt,
    output logic [2:0]               owner,
    output logic                     busy,
    output logic [WIDTH-1:0]         Q,
    output logic                     q_load
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {S_IDLE = 1'b0, S_OWN = 1'b1} state_t;

    state_t              r_state;
    logic [PW-1:0]       r_ptr;
    logic [PW-1:0]       r_own;
    logic [HW-1:0]       r_hold;
    logic [N_REQ-1:0]    r_gnt;
    logic                r_busy;
    logic [WIDTH-1:0]    r_q;
    logic                r_q_load;

    logic [PW-1:0]       w_start;
    logic [PW-1:0]       w_win;
    logic                w_found;
    logic                w_req_own;
    logic [WIDTH-1:0]    w_dsel;
    logic                w_lock_hold;
    logic                w_release;

    // Index following o, wrapping at N_REQ.
    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] o);
        if (int'(o) == N_REQ - 1)
            return '0;
        else
            return o + PW'(1);
    endfunction

    // One-hot encoding of a requester index.
    function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        for (int i = 0; i < N_REQ; i++)
            if (PW'(i) == idx)
                v[i] = 1'b1;
        return v;
    endfunction

    // Select the owner's request bit and data slice.
    always_comb begin
        w_req_own = 1'b0;
        w_dsel    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (PW'(i) == r_own) begin
                w_req_own = req[i];
                w_dsel    = D[i*WIDTH +: WIDTH];
            end
        end
    end

    // Round-robin search: from ptr when idle, from owner+1 when handing off,
    // so a released owner ends up last in priority.
    always_comb begin
        w_start = (r_state == S_OWN) ? next_idx(r_own) : r_ptr;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(w_start) + k) % N_REQ;
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_win   = PW'(idx);
            end
        end
    end

    // Release decision: owner dropped its request, or the hold limit is hit
    // and not suppressed by lock.
    always_comb begin
`ifdef DFF_ARB_LOCK_EN
        w_lock_hold = w_req_own && lock;
`else
        w_lock_hold = 1'b0;
`endif
        w_release = !w_req_own || ((r_hold == HOLD_LAST) && !w_lock_hold);
    end

    // Arbitration FSM with registered grant/owner/busy and the shared register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_own    <= '0;
            r_hold   <= '0;
            r_gnt    <= '0;
            r_busy   <= 1'b0;
            r_q      <= '0;
            r_q_load <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_q_load <= 1'b0;
                    if (w_found) begin
                        r_state <= S_OWN;
                        r_gnt   <= onehot(w_win);
                        r_own   <= w_win;
                        r_hold  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_OWN: begin
                    if (w_req_own) begin
                        r_q      <= w_dsel;
                        r_q_load <= 1'b1;
                    end else begin
                        r_q_load <= 1'b0;
                    end
                    if (!w_release) begin
                        // Saturate so a locked owner never wraps the counter.
                        if (r_hold != HOLD_LAST)
                            r_hold <= r_hold + HW'(1);
                    end else begin
                        r_ptr <= next_idx(r_own);
                        if (w_found) begin
                            r_gnt  <= onehot(w_win);
                            r_own  <= w_win;
                            r_hold <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_gnt   <= '0;
                            r_own   <= '0;
                            r_hold  <= '0;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt    = r_gnt;
    assign owner  = 3'(r_own);
    assign busy   = r_busy;
    assign Q      = r_q;
    assign q_load = r_q_load;

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Directed bench for dff_share_arbiter (N_REQ=4, WIDTH=8, MAX_HOLD=4).
module tb_dff_share_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] D;
`ifdef DFF_ARB_LOCK_EN
    logic        lock;
`endif
    logic [3:0]  gnt;
    logic [2:0]  owner;
    logic        busy;
    logic [7:0]  Q;
    logic        q_load;

    int n_vec;
    int n_miss;

    dff_share_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_HOLD(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .D      (D),
`ifdef DFF_ARB_LOCK_EN
        .lock   (lock),
`endif
        .gnt    (gnt),
        .owner  (owner),
        .busy   (busy),
        .Q      (Q),
        .q_load (q_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] eg, input logic [2:0] eo,
                           input logic eb, input logic [7:0] eq, input logic eql);
        chk({tag, ".gnt"},    32'(gnt),    32'(eg));
        chk({tag, ".owner"},  32'(owner),  32'(eo));
        chk({tag, ".busy"},   32'(busy),   32'(eb));
        chk({tag, ".Q"},      32'(Q),      32'(eq));
        chk({tag, ".q_load"}, 32'(q_load), 32'(eql));
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst    = 1'b1;
        req    = 4'b1111;
        D      = {8'h13, 8'h12, 8'h11, 8'h10};
`ifdef DFF_ARB_LOCK_EN
        lock   = 1'b0;
`endif
        // Reset held two cycles with all requests up.
        tick();
        chk_all("rst1", 4'b0000, 3'd0, 1'b0, 8'h00, 1'b0);
        tick();
        chk_all("rst2", 4'b0000, 3'd0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        tick();
        chk_all("rel_gnt", 4'b0001, 3'd0, 1'b1, 8'h00, 1'b0);
        tick();
        chk_all("rel_load", 4'b0001, 3'd0, 1'b1, 8'h10, 1'b1);
        req = 4'b0000;
        tick();
        chk_all("to_idle", 4'b0000, 3'd0, 1'b0, 8'h10, 1'b0);

        // Single requester 2 (ptr now 1).
        D   = {8'h13, 8'hA5, 8'h11, 8'h10};
        req = 4'b0100;
        tick();
        chk_all("s2_gnt", 4'b0100, 3'd2, 1'b1, 8'h10, 1'b0);
        tick();
        chk_all("s2_ld1", 4'b0100, 3'd2, 1'b1, 8'hA5, 1'b1);
        tick();
        chk_all("s2_ld2", 4'b0100, 3'd2, 1'b1, 8'hA5, 1'b1);
        req = 4'b0000;
        tick();
        chk_all("s2_idle", 4'b0000, 3'd0, 1'b0, 8'hA5, 1'b0);
        D = {8'h13, 8'hFF, 8'h11, 8'h10};
        tick();
        chk_all("idle_hold", 4'b0000, 3'd0, 1'b0, 8'hA5, 1'b0);

        // Asynchronous reset in the middle of a grant to requester 2.
        D   = {8'h13, 8'h5A, 8'h11, 8'h10};
        req = 4'b0100;
        tick();
        chk_all("m_gnt", 4'b0100, 3'd2, 1'b1, 8'hA5, 1'b0);
        tick();
        chk_all("m_ld", 4'b0100, 3'd2, 1'b1, 8'h5A, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_all("m_async", 4'b0000, 3'd0, 1'b0, 8'h00, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk_all("m_regnt", 4'b0100, 3'd2, 1'b1, 8'h00, 1'b0);
        tick();
        chk_all("m_reld", 4'b0100, 3'd2, 1'b1, 8'h5A, 1'b1);

        // Fairness: all four requesting, each owns exactly four cycles.
        rst = 1'b1;
        #1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        D   = {8'h13, 8'h12, 8'h11, 8'h10};
        tick();
        chk_all("f_first", 4'b0001, 3'd0, 1'b1, 8'h00, 1'b0);
        for (int j = 1; j <= 16; j++) begin
            chk("f_gnt_pre", 32'(gnt), 32'(4'b0001 << (((j - 1) / 4) % 4)));
            tick();
            chk("f_gnt", 32'(gnt), 32'(1) << ((j / 4) % 4));
            chk("f_Q", 32'(Q), 32'h10 + 32'((j - 1) / 4));
            chk("f_qload", 32'(q_load), 32'd1);
        end

        // Early release: owner 1 drops after two loads, handoff to 3.
        req = 4'b1010;
        tick();
        chk_all("e_gnt1", 4'b0010, 3'd1, 1'b1, 8'h13, 1'b0);
        tick();
        chk_all("e_ld1", 4'b0010, 3'd1, 1'b1, 8'h11, 1'b1);
        tick();
        chk_all("e_ld2", 4'b0010, 3'd1, 1'b1, 8'h11, 1'b1);
        req = 4'b1000;
        tick();
        chk_all("e_hand", 4'b1000, 3'd3, 1'b1, 8'h11, 1'b0);
        req = 4'b0000;
        tick();
        chk_all("e_idle", 4'b0000, 3'd0, 1'b0, 8'h11, 1'b0);

`ifdef DFF_ARB_LOCK_EN
        // Lock keeps owner 0 past the hold limit; dropping lock releases.
        req  = 4'b0011;
        lock = 1'b1;
        tick();
        chk_all("l_gnt", 4'b0001, 3'd0, 1'b1, 8'h11, 1'b0);
        for (int j = 0; j < 6; j++) begin
            tick();
            chk_all("l_hold", 4'b0001, 3'd0, 1'b1, 8'h10, 1'b1);
        end
        lock = 1'b0;
        tick();
        chk_all("l_rel", 4'b0010, 3'd1, 1'b1, 8'h10, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
